// File: rtl/cpu4_prog_sequencer_if.sv
// rtl/cpu4_prog_sequencer_if.sv - host/datapath bus bundle for the 4-bit CPU program sequencer
//
// Purpose: groups the program-load port, run control, accumulator feedback and the
// datapath drive/status signals of cpu4_prog_sequencer.
// Signals:
//   prog_we, prog_addr[3:0], prog_wdata[11:0]  instruction store write port (host -> sequencer)
//   start, stop                                run control pulses (host -> sequencer)
//   acc_in[3:0]                                datapath accumulator, used by JZ
//   dp_opcode/dp_addr/dp_data[3:0], dp_write_ena  datapath drive (sequencer -> datapath)
//   busy, done, halted, wr_reject, pc[3:0]     status (sequencer -> host)
// Modports: slave = sequencer side, master = host/datapath side.

interface cpu4_prog_sequencer_if;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_wdata;
  logic        start;
  logic        stop;
  logic [3:0]  acc_in;
  logic [3:0]  dp_opcode;
  logic [3:0]  dp_addr;
  logic [3:0]  dp_data;
  logic        dp_write_ena;
  logic        busy;
  logic        done;
  logic        halted;
  logic        wr_reject;
  logic [3:0]  pc;

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, stop, acc_in,
    output dp_opcode, dp_addr, dp_data, dp_write_ena, busy, done, halted, wr_reject, pc
  );

  modport master (
    output prog_we, prog_addr, prog_wdata, start, stop, acc_in,
    input  dp_opcode, dp_addr, dp_data, dp_write_ena, busy, done, halted, wr_reject, pc
  );
endinterface

// File: rtl/cpu4_prog_sequencer.sv
// rtl/cpu4_prog_sequencer.sv - instruction store and sequencer for the 4-bit accumulator CPU
//
// Purpose: holds a PROG_DEPTH x 12-bit program, steps through it and drives the datapath
// for ISSUE_CYCLES cycles per forwarded instruction. JMP (B), JZ (C) and HALT (F) are
// executed locally and never reach the datapath.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset (store reloads with HALT words)
//   bus  cpu4_prog_sequencer_if.slave: program load, start/stop, acc_in, dp_* drive, status

module cpu4_prog_sequencer #(
  parameter int PROG_DEPTH   = 16,
  parameter int ISSUE_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  cpu4_prog_sequencer_if.slave     bus
);

  localparam int         PCW       = $clog2(PROG_DEPTH);
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JZ     = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [11:0] HALT_WORD = 12'hF00;
  localparam logic [3:0] LAST_CNT  = 4'(ISSUE_CYCLES - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [11:0]    ir_q, ir_d;
  logic [3:0]     count_q, count_d;
  logic           done_q, done_d;
  logic           wr_reject_q, wr_reject_d;
  logic [11:0]    mem_q [PROG_DEPTH];
  logic [11:0]    mem_d [PROG_DEPTH];

  logic           busy;
  logic [11:0]    fetch_word;
  logic [3:0]     fetch_op;
  logic [PCW-1:0] fetch_tgt;

  assign busy       = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign fetch_word = mem_q[pc_q];
  assign fetch_op   = fetch_word[11:8];
  assign fetch_tgt  = PCW'(fetch_word[7:4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= HALT_WORD;
      count_q     <= '0;
      done_q      <= 1'b0;
      wr_reject_q <= 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= HALT_WORD;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      count_q     <= count_d;
      done_q      <= done_d;
      wr_reject_q <= wr_reject_d;
      mem_q       <= mem_d;
    end
  end

  // Store writes land on the same edge they are seen, so a write paired with start
  // is visible to the FETCH of pc=0 that follows.
  always_comb begin
    mem_d = mem_q;
    if (bus.prog_we && !busy) begin
      mem_d[bus.prog_addr[PCW-1:0]] = bus.prog_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    count_d     = count_q;
    wr_reject_d = bus.prog_we && busy;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          ir_d = fetch_word;
          case (fetch_op)
            OP_HALT: state_d = S_HALTED;
            // Branches resolve in the fetch cycle itself and go straight to the next fetch.
            OP_JMP:  pc_d = fetch_tgt;
            OP_JZ:   pc_d = (bus.acc_in == 4'h0) ? fetch_tgt : pc_q + PCW'(1);
            default: begin
              state_d = S_ISSUE;
              count_d = '0;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (count_q == LAST_CNT) begin
          // Running off the end of the store halts instead of wrapping to 0.
          if (pc_q == PC_LAST) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_q + PCW'(1);
            state_d = S_FETCH;
          end
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_HALTED) && (state_q != S_HALTED);
  end

  always_comb begin
    bus.dp_opcode    = OP_HALT;
    bus.dp_addr      = 4'h0;
    bus.dp_data      = 4'h0;
    bus.dp_write_ena = 1'b0;
    if (state_q == S_ISSUE) begin
      bus.dp_opcode    = ir_q[11:8];
      bus.dp_addr      = ir_q[7:4];
      bus.dp_data      = ir_q[3:0];
      bus.dp_write_ena = (ir_q[11:8] == OP_STORE);
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.halted    = (state_q == S_HALTED);
  assign bus.wr_reject = wr_reject_q;
  assign bus.pc        = 4'(pc_q);

endmodule
